// File: rtl/sram_burst_reader_pkg.sv
// sram_if_pkg: default SRAM widths and 3-bit FSM state encoding shared by SRAM initiators
package sram_if_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_PARK = 3'd1, ST_REQ = 3'd2, ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4, ST_ABORT = 3'd5, ST_RSVD = 3'd6;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE, PARK = ST_PARK, REQ = ST_REQ, HOLD = ST_HOLD,
    DONE = ST_DONE, ABORT = ST_ABORT, RSVD = ST_RSVD
  } state_t;
endpackage

// File: rtl/sram_burst_reader_if.sv
// sram_burst_reader_if: SRAM cen/address/ready bus plus downstream valid/ready stream; master = initiator, slave = SRAM + sink
interface sram_burst_reader_if import sram_if_pkg::*; #(
  parameter int addrWidth = ADDR_W,
  parameter int dataWidth = DATA_W
);
  logic cen;
  logic [addrWidth-1:0] address;
  logic [dataWidth-1:0] sram_rdata;
  logic sram_ready;
  logic [dataWidth-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master(output cen, address, out_data, out_valid, input sram_rdata, sram_ready, out_ready);
  modport slave(input cen, address, out_data, out_valid, output sram_rdata, sram_ready, out_ready);
endinterface

// File: rtl/sram_burst_reader_wait_timer.sv
// sram_wait_timer: clear/enable wait counter; ports clk, rst (sync active-low), clr, en in; expired out, registered, high during the TIMEOUT-th enabled cycle and sticky until clr
module sram_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst || clr) begin
      cnt <= '0;
      expired <= 1'b0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
      expired <= cnt == W'(TIMEOUT - 2);
    end
endmodule

// File: rtl/sram_burst_reader.sv
// sram_burst_reader: burst SRAM read initiator with wait timeout; ports clk, rst (sync active-low), start/base_addr/burst_len in, busy/done/err out, io = SRAM bus + output stream (master)
module sram_burst_reader import sram_if_pkg::*; #(
  parameter int addrWidth = ADDR_W,
  parameter int dataWidth = DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [addrWidth-1:0] base_addr,
  input  logic [addrWidth-1:0] burst_len,
  output logic busy,
  output logic done,
  output logic err,
  sram_burst_reader_if.master io
);
  state_t state, state_n;
  logic [addrWidth-1:0] addr_q, addr_n, rem_q, rem_n, address_q;
  logic [dataWidth-1:0] data_q, data_n;
  logic cen_q, valid_q, expired;
  sram_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clr(state != REQ), .en(state == REQ), .expired(expired)
  );
  assign io.cen = cen_q;
  assign io.address = address_q;
  assign io.out_data = data_q;
  assign io.out_valid = valid_q;
  always_comb begin
    state_n = state;
    addr_n = addr_q;
    rem_n = rem_q;
    data_n = data_q;
    case (state)
      IDLE: if (start) begin
        state_n = burst_len == '0 ? DONE : PARK;
        addr_n = burst_len == '0 ? addr_q : base_addr;
        rem_n = burst_len;
      end
      PARK: state_n = REQ;
      REQ: if (io.sram_ready) begin
        state_n = HOLD;
        data_n = io.sram_rdata;
      end else if (expired) state_n = ABORT;
      HOLD: if (io.out_ready) begin
        state_n = rem_q == addrWidth'(1) ? DONE : REQ;
        addr_n = rem_q == addrWidth'(1) ? addr_q : addr_q + 1'b1;
        rem_n = rem_q - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  // PARK drives the inverted address so the first REQ is always seen as an address change.
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      data_q <= '0;
      address_q <= '0;
      cen_q <= 1'b0;
      valid_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      addr_q <= addr_n;
      rem_q <= rem_n;
      data_q <= data_n;
      address_q <= state_n == PARK ? ~addr_n : addr_n;
      cen_q <= state_n == REQ;
      valid_q <= state_n == HOLD;
      busy <= state_n != IDLE;
      done <= state_n == DONE || state_n == ABORT;
      err <= state_n == ABORT;
    end
endmodule

// File: tb/tb_sram_burst_reader.sv
// tb_sram_burst_reader: directed bench for sram_burst_reader with a two-cycle SRAM ready generator model
module tb_sram_burst_reader;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [11:0] base_addr = '0, burst_len = '0;
  logic busy, done, err;
  int n_chk = 0, n_fail = 0;
  sram_burst_reader_if io();
  sram_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .busy(busy), .done(done), .err(err), .io(io)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] f(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h5A5A;
  endfunction
  logic gen_en = 1'b1, g_chg = 1'b0;
  logic [11:0] g_prev = '0;
  always @(posedge clk) begin
    g_prev <= io.address;
    g_chg <= io.cen && io.address != g_prev;
    io.sram_ready <= gen_en && g_chg;
    io.sram_rdata <= (gen_en && g_chg) ? f(g_prev) : 16'hDEAD;
  end
  int nw, cen_cnt, done_k, err_k, done_cnt, err_cnt;
  int wk[8];
  logic [15:0] wd[8];
  logic busy_after, cen_k1;
  logic [11:0] addr_k1;
  task automatic run_burst(input logic [11:0] b, input logic [11:0] l);
    nw = 0; cen_cnt = 0; done_k = -1; err_k = -1; done_cnt = 0; err_cnt = 0;
    busy_after = 1'bx; cen_k1 = 1'bx; addr_k1 = 'x;
    for (int i = 0; i < 8; i++) begin wk[i] = -1; wd[i] = 'x; end
    start = 1'b1; base_addr = b; burst_len = l;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) begin addr_k1 = io.address; cen_k1 = io.cen; end
      if (io.cen) cen_cnt++;
      if (io.out_valid && io.out_ready && nw < 8) begin wk[nw] = k; wd[nw] = io.out_data; nw++; end
      if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (err) begin err_cnt++; if (err_k < 0) err_k = k; end
      if (done_k > 0 && k == done_k + 1) begin busy_after = busy; break; end
    end
    n_chk++; if (done_k < 0) begin n_fail++; $display("FAIL burst_end: no done within 40 cycles base=%0h len=%0d", b, l); end
  endtask
  task automatic test_reset();
    io.out_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, err, io.cen, io.address, io.out_valid, io.out_data} !== 33'd0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b err=%b cen=%b addr=%h valid=%b data=%h required all 0",
        busy, done, err, io.cen, io.address, io.out_valid, io.out_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_release: busy=%b done=%b required 0 0", busy, done); end
  endtask
  task automatic test_single();
    run_burst(12'h010, 12'd1);
    n_chk++; if (cen_cnt !== 3) begin n_fail++; $display("FAIL single_cen: %0d cycles required 3", cen_cnt); end
    n_chk++; if (nw !== 1 || wk[0] !== 5) begin n_fail++; $display("FAIL single_latency: words=%0d cycle=%0d required 1 at 5", nw, wk[0]); end
    n_chk++; if (wd[0] !== f(12'h010)) begin n_fail++; $display("FAIL single_data: got %h required %h", wd[0], f(12'h010)); end
    n_chk++; if (done_k !== 6 || err_cnt !== 0) begin n_fail++; $display("FAIL single_done: done at %0d err=%0d required 6 0", done_k, err_cnt); end
    n_chk++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b required 0", busy_after); end
  endtask
  task automatic test_four();
    run_burst(12'h3FE, 12'd4);
    n_chk++; if (nw !== 4) begin n_fail++; $display("FAIL four_count: got %0d required 4", nw); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (wk[i] !== 5 + 4 * i || wd[i] !== f(12'(12'h3FE + i))) begin
        n_fail++; $display("FAIL four_word%0d: cycle=%0d data=%h required %0d %h", i, wk[i], wd[i], 5 + 4 * i, f(12'(12'h3FE + i)));
      end
    end
    n_chk++; if (done_k !== 18 || err_cnt !== 0) begin n_fail++; $display("FAIL four_done: at %0d err=%0d required 18 0", done_k, err_cnt); end
  endtask
  task automatic test_same_addr();
    run_burst(12'h401, 12'd1);
    n_chk++; if (cen_k1 !== 1'b0 || addr_k1 !== 12'hBFE) begin n_fail++; $display("FAIL park_addr: cen=%b addr=%h required 0 bfe", cen_k1, addr_k1); end
    n_chk++; if (nw !== 1 || wd[0] !== f(12'h401)) begin n_fail++; $display("FAIL same_data: words=%0d data=%h required 1 %h", nw, wd[0], f(12'h401)); end
    n_chk++; if (done_k !== 6) begin n_fail++; $display("FAIL same_done: at %0d required 6", done_k); end
  endtask
  task automatic test_backpressure();
    logic [15:0] d0;
    d0 = f(12'h100);
    io.out_ready = 1'b0; start = 1'b1; base_addr = 12'h100; burst_len = 12'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (io.out_valid !== 1'b1 || io.out_data !== d0 || io.cen !== 1'b0 || io.address !== 12'h100) begin
        n_fail++; $display("FAIL stall_%0d: valid=%b data=%h cen=%b addr=%h required 1 %h 0 100", i, io.out_valid, io.out_data, io.cen, io.address, d0);
      end
      start = i < 5; base_addr = 12'h7AA; burst_len = 12'd5;
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (io.cen !== 1'b1 || io.address !== 12'h101 || io.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_req: cen=%b addr=%h valid=%b required 1 101 0", io.cen, io.address, io.out_valid);
    end
    repeat (3) @(negedge clk);
    n_chk++; if (io.out_valid !== 1'b1 || io.out_data !== f(12'h101)) begin
      n_fail++; $display("FAIL bp_word1: valid=%b data=%h required 1 %h", io.out_valid, io.out_data, f(12'h101));
    end
    @(negedge clk);
    n_chk++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL bp_done: done=%b err=%b required 1 0", done, err); end
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: busy=%b required 0", busy); end
  endtask
  task automatic test_timeout();
    gen_en = 1'b0;
    run_burst(12'h200, 12'd3);
    gen_en = 1'b1;
    n_chk++; if (cen_cnt !== 15) begin n_fail++; $display("FAIL to_cen: %0d cycles required 15", cen_cnt); end
    n_chk++; if (done_k !== 17 || err_k !== 17) begin n_fail++; $display("FAIL to_when: done at %0d err at %0d required 17 17", done_k, err_k); end
    n_chk++; if (done_cnt !== 1 || err_cnt !== 1 || nw !== 0) begin
      n_fail++; $display("FAIL to_pulses: done=%0d err=%0d words=%0d required 1 1 0", done_cnt, err_cnt, nw);
    end
    n_chk++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL to_idle: busy=%b required 0", busy_after); end
  endtask
  task automatic test_len0();
    run_burst(12'h055, 12'd0);
    n_chk++; if (done_k !== 1 || cen_cnt !== 0 || err_cnt !== 0) begin
      n_fail++; $display("FAIL len0: done at %0d cen=%0d err=%0d required 1 0 0", done_k, cen_cnt, err_cnt);
    end
    n_chk++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL len0_idle: busy=%b required 0", busy_after); end
  endtask
  task automatic test_reset_mid();
    logic seen;
    start = 1'b1; base_addr = 12'h300; burst_len = 12'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_chk++; if (io.cen !== 1'b1) begin n_fail++; $display("FAIL mid_req: cen=%b required 1", io.cen); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, done, err, io.cen, io.address, io.out_valid, io.out_data} !== 33'd0) begin
      n_fail++; $display("FAIL mid_reset: busy=%b done=%b err=%b cen=%b addr=%h valid=%b data=%h required all 0",
        busy, done, err, io.cen, io.address, io.out_valid, io.out_data);
    end
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen = seen | done | busy; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_silent: done/busy seen=%b required 0", seen); end
  endtask
  task automatic test_wrap();
    run_burst(12'hFFF, 12'd2);
    n_chk++; if (nw !== 2 || wd[0] !== f(12'hFFF) || wd[1] !== f(12'h000)) begin
      n_fail++; $display("FAIL wrap_data: words=%0d %h %h required 2 %h %h", nw, wd[0], wd[1], f(12'hFFF), f(12'h000));
    end
    n_chk++; if (wk[1] !== 9 || done_k !== 10) begin n_fail++; $display("FAIL wrap_timing: word1 at %0d done at %0d required 9 10", wk[1], done_k); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_four();
    test_same_addr();
    test_backpressure();
    test_timeout();
    test_len0();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
